// File: rtl/dmem_unit.sv
// MEM-stage data memory unit: direct-mapped, write-through, no-write-allocate cache
// with one word per line, a valid/ack word bus towards memory and load hit/miss counters.
module dmem_unit #(
    parameter int          LINES   = 16,
    parameter logic [31:0] ADDR_LO = 32'h8000_0000,
    parameter logic [31:0] ADDR_HI = 32'h87ff_ffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_en,
    input  logic        w_en,
    input  logic [9:0]  funct,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;

    // Access codes as defined in define.v (funct3 in [2:0], bit 3 marks a store).
    localparam logic [9:0] FUNC_LB  = 10'h000;
    localparam logic [9:0] FUNC_LH  = 10'h001;
    localparam logic [9:0] FUNC_LW  = 10'h002;
    localparam logic [9:0] FUNC_LBU = 10'h004;
    localparam logic [9:0] FUNC_LHU = 10'h005;
    localparam logic [9:0] FUNC_SB  = 10'h008;
    localparam logic [9:0] FUNC_SH  = 10'h009;
    localparam logic [9:0] FUNC_SW  = 10'h00A;

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT, S_RESP} state_t;

    state_t            r_state, w_state_next;
    logic [LINES-1:0]  r_valid;
    logic [TAGW-1:0]   r_tag_mem [LINES];
    logic [31:0]       r_data_mem [LINES];
    logic [31:0]       r_result, r_hit_cnt, r_miss_cnt;
    logic              r_mem_req, r_mem_we;
    logic [31:0]       r_mem_addr, r_mem_wdata;
    logic [3:0]        r_mem_wstrb;
    logic [1:0]        r_lane;
    logic [9:0]        r_funct;

    logic [IDX-1:0]    w_idx, w_r_idx;
    logic [TAGW-1:0]   w_tag, w_r_tag;
    logic              w_is_ld, w_is_st, w_half, w_word, w_byte;
    logic              w_fault, w_in_range, w_hit, w_go, w_ld_hit, w_ld_miss, w_st, w_wr_hit;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata_rep, w_merged, w_rdata;
    logic              w_busy;

    function automatic logic [31:0] f_format(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [9:0] f);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f)
            FUNC_LB:  return {{24{b[7]}}, b};
            FUNC_LBU: return {24'h0, b};
            FUNC_LH:  return {{16{h[15]}}, h};
            FUNC_LHU: return {16'h0, h};
            default:  return word;
        endcase
    endfunction

    assign w_idx   = addr[IDX+1:2];
    assign w_tag   = addr[31:IDX+2];
    assign w_r_idx = r_mem_addr[IDX+1:2];
    assign w_r_tag = r_mem_addr[31:IDX+2];

    assign w_is_ld = (funct == FUNC_LB) || (funct == FUNC_LH) || (funct == FUNC_LW) ||
                     (funct == FUNC_LBU) || (funct == FUNC_LHU);
    assign w_is_st = (funct == FUNC_SB) || (funct == FUNC_SH) || (funct == FUNC_SW);
    assign w_byte  = (funct == FUNC_LB) || (funct == FUNC_LBU) || (funct == FUNC_SB);
    assign w_half  = (funct == FUNC_LH) || (funct == FUNC_LHU) || (funct == FUNC_SH);
    assign w_word  = (funct == FUNC_LW) || (funct == FUNC_SW);

    // Unknown codes are treated as illegal requests alongside misalignment.
    assign w_fault = (r_state == S_IDLE) &&
                     ((r_en && w_en) ||
                      (r_en && !w_is_ld) || (w_en && !w_is_st) ||
                      ((r_en || w_en) && ((w_half && addr[0]) || (w_word && addr[1:0] != 2'b00))));

    assign w_in_range = (addr >= ADDR_LO) && (addr <= ADDR_HI);
    assign w_hit      = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
    assign w_go       = (r_state == S_IDLE) && !w_fault && w_in_range;
    assign w_ld_hit   = w_go && r_en && w_hit;
    assign w_ld_miss  = w_go && r_en && !w_hit;
    assign w_st       = w_go && w_en;
    assign w_wr_hit   = r_valid[w_r_idx] && (r_tag_mem[w_r_idx] == w_r_tag);

    always_comb begin
        w_wstrb     = 4'b1111;
        w_wdata_rep = wdata;
        if (w_byte) begin
            w_wstrb     = 4'b0001 << addr[1:0];
            w_wdata_rep = {4{wdata[7:0]}};
        end else if (w_half) begin
            w_wstrb     = 4'b0011 << {addr[1], 1'b0};
            w_wdata_rep = {2{wdata[15:0]}};
        end
    end

    // Store-hit merge: take strobed bytes from the bus word, keep the rest of the line.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign w_merged[8*gi +: 8] = r_mem_wstrb[gi] ? r_mem_wdata[8*gi +: 8]
                                                         : r_data_mem[w_r_idx][8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_rdata      = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_ld_hit) w_rdata = f_format(r_data_mem[w_idx], addr[1:0], funct);
                if (w_ld_miss) begin
                    w_busy       = 1'b1;
                    w_state_next = S_RD_WAIT;
                end else if (w_st) begin
                    w_busy       = 1'b1;
                    w_state_next = S_WR_WAIT;
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                w_busy = 1'b1;
                if (mem_ack) w_state_next = S_RESP;
            end
            default: begin
                w_rdata      = r_result;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_hit_cnt   <= 32'h0;
            r_miss_cnt  <= 32'h0;
            r_result    <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
            r_lane      <= 2'b00;
            r_funct     <= 10'h0;
        end else begin
            if (w_ld_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_ld_miss || w_st) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_st;
                r_mem_addr  <= {addr[31:2], 2'b00};
                r_mem_wdata <= w_st ? w_wdata_rep : 32'h0;
                r_mem_wstrb <= w_st ? w_wstrb : 4'h0;
                r_lane      <= addr[1:0];
                r_funct     <= funct;
            end
            if (w_ld_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
            if (r_state == S_RD_WAIT && mem_ack) begin
                r_mem_req        <= 1'b0;
                r_valid[w_r_idx] <= 1'b1;
                r_result         <= f_format(mem_rdata, r_lane, r_funct);
            end
            if (r_state == S_WR_WAIT && mem_ack) begin
                r_mem_req <= 1'b0;
                r_result  <= 32'h0;
            end
        end
    end

    // Tag/data storage carries no reset; only the valid bits define cache contents.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_RD_WAIT && mem_ack) begin
            r_tag_mem[w_r_idx]  <= w_r_tag;
            r_data_mem[w_r_idx] <= mem_rdata;
        end else if (!rst && r_state == S_WR_WAIT && mem_ack && w_wr_hit) begin
            r_data_mem[w_r_idx] <= w_merged;
        end
    end

    assign rdata     = w_rdata;
    assign busy      = w_busy;
    assign fault     = w_fault;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;
endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: a word-level cache model predicts every cycle's outputs,
// a negedge process compares them, and literal values pin the model on key cases.
module tb_dmem_unit;
    localparam logic [9:0] LB = 10'h000, LH = 10'h001, LW = 10'h002, LBU = 10'h004, LHU = 10'h005;
    localparam logic [9:0] SB = 10'h008, SH = 10'h009, SW = 10'h00A;

    logic        clk = 1'b0;
    logic        rst, r_en, w_en, mem_ack;
    logic [9:0]  funct;
    logic [31:0] addr, wdata, mem_rdata;
    logic [31:0] rdata, mem_addr, mem_wdata, hit_cnt, miss_cnt;
    logic        busy, fault, mem_req, mem_we;
    logic [3:0]  mem_wstrb;

    dmem_unit #(.LINES(16), .ADDR_LO(32'h8000_0000), .ADDR_HI(32'h87ff_ffff)) dut (
        .clk(clk), .rst(rst), .r_en(r_en), .w_en(w_en), .funct(funct), .addr(addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .fault(fault), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each line remembers which word address it holds.
    bit          m_valid [16];
    logic [31:0] m_waddr [16];
    logic [31:0] m_data  [16];
    logic [31:0] m_hit = 0, m_miss = 0;

    logic        chk_en = 1'b0;
    logic        e_busy, e_fault, e_req, e_we;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] got, last_wdata;
    logic [3:0]  last_wstrb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("fault", 32'(fault), 32'(e_fault));
            chk("rdata", rdata, e_rdata);
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("hit_cnt", hit_cnt, m_hit);
            chk("miss_cnt", miss_cnt, m_miss);
            if (e_req) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    function automatic logic [31:0] fm(input logic [31:0] w, input logic [31:0] a, input logic [9:0] f);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (f)
            LB:      return (b >= 128) ? b - 32'd256 : b;
            LBU:     return b;
            LH:      return (h >= 32768) ? h - 32'd65536 : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    function automatic bit is_fault(input bit rd, input bit wr, input logic [9:0] f, input logic [31:0] a);
        bit ld_ok, st_ok;
        ld_ok = (f == LB || f == LH || f == LW || f == LBU || f == LHU);
        st_ok = (f == SB || f == SH || f == SW);
        if (rd && wr) return 1'b1;
        if (rd && !ld_ok) return 1'b1;
        if (wr && !st_ok) return 1'b1;
        if ((f == LH || f == LHU || f == SH) && (a % 2 != 0)) return 1'b1;
        if ((f == LW || f == SW) && (a % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_expect();
        e_busy = 0; e_fault = 0; e_req = 0; e_we = 0;
        e_rdata = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [9:0] f, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] memw, input int ack_wait);
        bit flt, inr, hit;
        int idx;
        logic [3:0]  strb;
        logic [31:0] rep, msk;
        @(posedge clk); #1;
        r_en = rd; w_en = wr; funct = f; addr = a; wdata = wd; mem_rdata = memw;
        flt = is_fault(rd, wr, f, a);
        inr = (a >= 32'h8000_0000) && (a <= 32'h87ff_ffff);
        idx = int'((a >> 2) % 16);
        hit = m_valid[idx] && (m_waddr[idx] == (a >> 2));
        if (f == SB) begin strb = 4'(1 << (a % 4)); rep = (wd & 32'hFF) * 32'h0101_0101; end
        else if (f == SH) begin strb = 4'(3 << (a % 4)); rep = (wd & 32'hFFFF) * 32'h0001_0001; end
        else begin strb = 4'hF; rep = wd; end
        idle_expect();
        e_fault = flt;
        if (flt || !inr || (rd && hit)) begin
            if (!flt && inr) e_rdata = fm(m_data[idx], a, f);
            @(negedge clk); got = rdata;
            @(posedge clk); #1;
            if (!flt && inr) m_hit++;
        end else begin
            e_busy = 1;
            @(negedge clk);
            @(posedge clk); #1;
            if (rd) m_miss++;
            e_req = 1; e_we = wr; e_addr = a & ~32'd3;
            e_wstrb = wr ? strb : 4'h0; e_wdata = rep;
            for (int i = 0; i <= ack_wait; i++) begin
                mem_ack = (i == ack_wait);
                @(negedge clk);
                if (i == 0) begin last_wstrb = mem_wstrb; last_wdata = mem_wdata; end
                @(posedge clk); #1;
            end
            mem_ack = 0;
            if (rd) begin
                m_valid[idx] = 1; m_waddr[idx] = a >> 2; m_data[idx] = memw;
            end else if (hit) begin
                for (int k = 0; k < 4; k++) begin
                    if (strb[k]) begin
                        msk = 32'hFF << (8 * k);
                        m_data[idx] = (m_data[idx] & ~msk) | (rep & msk);
                    end
                end
            end
            idle_expect();
            e_rdata = rd ? fm(memw, a, f) : 32'h0;
            @(negedge clk); got = rdata;
            @(posedge clk); #1;
        end
        r_en = 0; w_en = 0;
        idle_expect();
        @(negedge clk);
        $display("[TB] txn rd=%0b wr=%0b funct=%h addr=%h wdata=%h rdata=%h hits=%0d misses=%0d",
                 rd, wr, f, a, wd, got, hit_cnt, miss_cnt);
    endtask

    initial begin
        rst = 1; r_en = 0; w_en = 0; funct = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
        foreach (m_valid[i]) m_valid[i] = 0;
        foreach (m_data[i]) begin m_data[i] = 0; m_waddr[i] = 0; end
        idle_expect();
        repeat (2) @(posedge clk);
        #1 rst = 0; chk_en = 1;

        do_access(1, 0, LW, 32'h8000_0010, 0, 32'hDEAD_BEEF, 2);
        chk("lit_lw_miss", got, 32'hDEAD_BEEF);
        do_access(1, 0, LW, 32'h8000_0010, 0, 32'h0, 0);
        chk("lit_lw_hit", got, 32'hDEAD_BEEF);
        chk("lit_hit_cnt", hit_cnt, 32'd1);
        do_access(0, 1, SW, 32'h8000_0010, 32'h8081_F2F3, 0, 0);
        do_access(1, 0, LB,  32'h8000_0011, 0, 0, 0); chk("lit_lb",  got, 32'hFFFF_FFF2);
        do_access(1, 0, LBU, 32'h8000_0013, 0, 0, 0); chk("lit_lbu", got, 32'h0000_0080);
        do_access(1, 0, LH,  32'h8000_0012, 0, 0, 0); chk("lit_lh",  got, 32'hFFFF_8081);
        do_access(1, 0, LHU, 32'h8000_0010, 0, 0, 0); chk("lit_lhu", got, 32'h0000_F2F3);
        do_access(0, 1, SB, 32'h8000_0011, 32'h0000_00AA, 0, 1);
        chk("lit_sb_strb", 32'(last_wstrb), 32'h2);
        chk("lit_sb_wdata", last_wdata, 32'hAAAA_AAAA);
        do_access(1, 0, LW, 32'h8000_0010, 0, 0, 0); chk("lit_lw_merged", got, 32'h8081_AAF3);
        do_access(0, 1, SH, 32'h8000_0016, 32'h0000_BEEF, 0, 0);
        chk("lit_sh_strb", 32'(last_wstrb), 32'hC);

        do_access(0, 1, SW, 32'h8000_0400, 32'h1122_3344, 0, 1);
        do_access(1, 0, LW, 32'h8000_0400, 0, 32'h1122_3344, 0);
        chk("lit_nwa_miss", miss_cnt, 32'd2);

        do_access(1, 0, LW, 32'h8000_0002, 0, 0, 0);
        do_access(1, 0, LH, 32'h8000_0001, 0, 0, 0);
        do_access(1, 1, LW, 32'h8000_0010, 0, 0, 0);
        do_access(0, 1, SH, 32'h8000_0013, 32'h1234, 0, 0);
        do_access(1, 0, 10'h3FF, 32'h8000_0010, 0, 0, 0);

        do_access(1, 0, LW, 32'h0000_1000, 0, 0, 0);
        do_access(0, 1, SW, 32'h0000_1000, 32'h5555_5555, 0, 0);
        do_access(1, 0, LW, 32'h8800_0000, 0, 0, 0);
        do_access(1, 0, LW, 32'h87FF_FFFC, 0, 32'hCAFE_F00D, 1);
        do_access(1, 0, LW, 32'h8000_0050, 0, 32'h5566_7788, 0);
        do_access(1, 0, LB, 32'h8000_0010, 0, 32'h8081_AAF3, 0);
        chk("lit_evict_lb", got, 32'hFFFF_FFF3);

        // Reset while a miss is outstanding, then an ack arriving too late.
        @(posedge clk); #1;
        r_en = 1; funct = LW; addr = 32'h8000_0030;
        idle_expect(); e_busy = 1;
        @(posedge clk); #1;
        m_miss++; e_req = 1; e_addr = 32'h8000_0030; e_wstrb = 0; e_we = 0;
        @(posedge clk); #1;
        rst = 1; chk_en = 0;
        @(posedge clk); #1;
        rst = 0; r_en = 0; mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        foreach (m_valid[i]) m_valid[i] = 0;
        m_hit = 0; m_miss = 0;
        idle_expect(); chk_en = 1;
        @(posedge clk); #1;
        mem_ack = 0;
        do_access(1, 0, LW, 32'h8000_0030, 0, 32'h0BAD_F00D, 0);
        chk("lit_after_rst", got, 32'h0BAD_F00D);
        do_access(1, 0, LW, 32'h8000_0010, 0, 32'h8081_AAF3, 2);
        chk("lit_rst_miss_cnt", miss_cnt, 32'd2);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
